// File: rtl/udp_usr_rx_sink.sv
// udp_usr_rx_sink: joins UDP headers with their payload, forwards accepted
// packets plus one status record each, drops the rest, keeps statistics.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_usr_hdr_*                   112-bit UDP header in (valid/ready)
//   s_usr_payload_axis_*          64-bit payload in (tdata/tkeep/tlast/tuser)
//   m_pkt_axis_*                  forwarded payload out (combinational)
//   m_status_*                    per-packet status record (valid/ready)
//   rx_pkt_count/drop/err         saturating 32-bit statistics
module udp_usr_rx_sink #(
   parameter logic [15:0] LOCAL_PORT     = 16'd1234,
   parameter bit          PORT_FILTER_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [111:0]  s_usr_hdr_data,
   input  logic          s_usr_hdr_valid,
   output logic          s_usr_hdr_ready,
   input  logic [63:0]   s_usr_payload_axis_tdata,
   input  logic [7:0]    s_usr_payload_axis_tkeep,
   input  logic          s_usr_payload_axis_tvalid,
   output logic          s_usr_payload_axis_tready,
   input  logic          s_usr_payload_axis_tlast,
   input  logic          s_usr_payload_axis_tuser,
   output logic [63:0]   m_pkt_axis_tdata,
   output logic [7:0]    m_pkt_axis_tkeep,
   output logic          m_pkt_axis_tlast,
   output logic          m_pkt_axis_tvalid,
   input  logic          m_pkt_axis_tready,
   output logic          m_status_valid,
   input  logic          m_status_ready,
   output logic [31:0]   m_status_src_ip,
   output logic [15:0]   m_status_src_port,
   output logic [15:0]   m_status_len,
   output logic [2:0]    m_status_err,
   output logic [31:0]   rx_pkt_count,
   output logic [31:0]   rx_drop_count,
   output logic [31:0]   rx_err_count
);

   typedef enum logic [1:0] {IDLE, PASS, DROP, STATUS} state_t;

   state_t state, state_nxt;

   logic [31:0] src_ip;
   logic [15:0] src_port;
   logic [15:0] expected;
   logic [16:0] count;
   logic [1:0]  err;

   logic [15:0] hdr_len;
   logic [15:0] hdr_dport;
   logic        hdr_short;
   logic        hdr_filtered;
   logic        hdr_fire;
   logic        beat_fire;
   logic        sts_fire;
   logic [3:0]  beat_bytes;
   logic [17:0] count_sum;
   logic [16:0] count_nxt;
   logic        unused_bits;

   function automatic logic [3:0] popcount(input logic [7:0] k);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, k[i]};
      return n;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign hdr_len      = s_usr_hdr_data[111:96];
   assign hdr_dport    = s_usr_hdr_data[95:80];
   assign hdr_short    = hdr_len < 16'd8;
   assign hdr_filtered = PORT_FILTER_EN && (hdr_dport != LOCAL_PORT);
   assign unused_bits  = ^s_usr_hdr_data[63:32];

   assign hdr_fire  = s_usr_hdr_valid && s_usr_hdr_ready;
   assign beat_fire = s_usr_payload_axis_tvalid && s_usr_payload_axis_tready;
   assign sts_fire  = m_status_valid && m_status_ready;

   // 17-bit byte counter saturates instead of wrapping
   assign beat_bytes = popcount(s_usr_payload_axis_tkeep);
   assign count_sum  = {1'b0, count} + {14'd0, beat_bytes};
   assign count_nxt  = count_sum[17] ? 17'h1FFFF : count_sum[16:0];

   assign m_pkt_axis_tdata  = s_usr_payload_axis_tdata;
   assign m_pkt_axis_tkeep  = s_usr_payload_axis_tkeep;
   assign m_pkt_axis_tlast  = s_usr_payload_axis_tlast;

   assign m_status_src_ip   = src_ip;
   assign m_status_src_port = src_port;
   assign m_status_len      = count[16] ? 16'hFFFF : count[15:0];
   assign m_status_err      = {1'b0, err};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // handshake outputs are held low for the whole reset cycle
   always_comb begin
      state_nxt                 = state;
      s_usr_hdr_ready           = 1'b0;
      s_usr_payload_axis_tready = 1'b0;
      m_pkt_axis_tvalid         = 1'b0;
      m_status_valid            = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               s_usr_hdr_ready = 1'b1;
               if (s_usr_hdr_valid)
                  state_nxt = (hdr_short || hdr_filtered) ? DROP : PASS;
            end
            PASS: begin
               s_usr_payload_axis_tready = m_pkt_axis_tready;
               m_pkt_axis_tvalid         = s_usr_payload_axis_tvalid;
               if (s_usr_payload_axis_tvalid && m_pkt_axis_tready &&
                   s_usr_payload_axis_tlast)
                  state_nxt = STATUS;
            end
            DROP: begin
               s_usr_payload_axis_tready = 1'b1;
               if (s_usr_payload_axis_tvalid && s_usr_payload_axis_tlast)
                  state_nxt = IDLE;
            end
            STATUS: begin
               m_status_valid = 1'b1;
               if (m_status_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_ip        <= '0;
         src_port      <= '0;
         expected      <= '0;
         count         <= '0;
         err           <= '0;
         rx_pkt_count  <= '0;
         rx_drop_count <= '0;
         rx_err_count  <= '0;
      end else begin
         if (hdr_fire) begin
            src_ip   <= s_usr_hdr_data[31:0];
            src_port <= s_usr_hdr_data[79:64];
            expected <= hdr_len - 16'd8;
            count    <= '0;
            err      <= '0;
            if (hdr_short) begin
               rx_err_count  <= sat_inc(rx_err_count);
               rx_drop_count <= sat_inc(rx_drop_count);
            end else if (hdr_filtered) begin
               rx_drop_count <= sat_inc(rx_drop_count);
            end
         end
         if (state == PASS && beat_fire) begin
            count <= count_nxt;
            if (s_usr_payload_axis_tlast)
               err <= {s_usr_payload_axis_tuser,
                       count_nxt != {1'b0, expected}};
         end
         if (sts_fire) begin
            rx_pkt_count <= sat_inc(rx_pkt_count);
            if (err != 2'b00) rx_err_count <= sat_inc(rx_err_count);
         end
      end
   end

endmodule

// File: tb/tb_udp_usr_rx_sink.sv
// tb_udp_usr_rx_sink: drives headers and payload into udp_usr_rx_sink and
// checks forwarded beats, status records and counters against a model.
module tb_udp_usr_rx_sink;

   typedef logic [72:0] beat_t;
   typedef logic [66:0] sts_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [111:0]  s_usr_hdr_data = '0;
   logic          s_usr_hdr_valid = 1'b0;
   logic          s_usr_hdr_ready;
   logic [63:0]   s_usr_payload_axis_tdata = '0;
   logic [7:0]    s_usr_payload_axis_tkeep = '0;
   logic          s_usr_payload_axis_tvalid = 1'b0;
   logic          s_usr_payload_axis_tready;
   logic          s_usr_payload_axis_tlast = 1'b0;
   logic          s_usr_payload_axis_tuser = 1'b0;
   logic [63:0]   m_pkt_axis_tdata;
   logic [7:0]    m_pkt_axis_tkeep;
   logic          m_pkt_axis_tlast;
   logic          m_pkt_axis_tvalid;
   logic          m_pkt_axis_tready = 1'b1;
   logic          m_status_valid;
   logic          m_status_ready = 1'b1;
   logic [31:0]   m_status_src_ip;
   logic [15:0]   m_status_src_port;
   logic [15:0]   m_status_len;
   logic [2:0]    m_status_err;
   logic [31:0]   rx_pkt_count;
   logic [31:0]   rx_drop_count;
   logic [31:0]   rx_err_count;

   int n_cmp = 0;
   int n_bad = 0;
   int e_pkt = 0;
   int e_drop = 0;
   int e_err = 0;
   int prdy_mode = 0;
   bit srdy_hold = 1'b0;
   bit srdy_rand = 1'b0;

   beat_t got_b[$];
   beat_t exp_b[$];
   sts_t  got_s[$];
   sts_t  exp_s[$];
   logic [63:0] b_data[$];
   logic [7:0]  b_keep[$];
   bit          b_user;

   localparam logic [111:0] NOM_HDR =
      {16'd24, 16'd1234, 16'd1000, 32'h8001A8C0, 32'h8101A8C0};

   udp_usr_rx_sink dut (
      .clk                       (clk),
      .rst                       (rst),
      .s_usr_hdr_data            (s_usr_hdr_data),
      .s_usr_hdr_valid           (s_usr_hdr_valid),
      .s_usr_hdr_ready           (s_usr_hdr_ready),
      .s_usr_payload_axis_tdata  (s_usr_payload_axis_tdata),
      .s_usr_payload_axis_tkeep  (s_usr_payload_axis_tkeep),
      .s_usr_payload_axis_tvalid (s_usr_payload_axis_tvalid),
      .s_usr_payload_axis_tready (s_usr_payload_axis_tready),
      .s_usr_payload_axis_tlast  (s_usr_payload_axis_tlast),
      .s_usr_payload_axis_tuser  (s_usr_payload_axis_tuser),
      .m_pkt_axis_tdata          (m_pkt_axis_tdata),
      .m_pkt_axis_tkeep          (m_pkt_axis_tkeep),
      .m_pkt_axis_tlast          (m_pkt_axis_tlast),
      .m_pkt_axis_tvalid         (m_pkt_axis_tvalid),
      .m_pkt_axis_tready         (m_pkt_axis_tready),
      .m_status_valid            (m_status_valid),
      .m_status_ready            (m_status_ready),
      .m_status_src_ip           (m_status_src_ip),
      .m_status_src_port         (m_status_src_port),
      .m_status_len              (m_status_len),
      .m_status_err              (m_status_err),
      .rx_pkt_count              (rx_pkt_count),
      .rx_drop_count             (rx_drop_count),
      .rx_err_count              (rx_err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      case (prdy_mode)
         0:       m_pkt_axis_tready = 1'b1;
         1:       m_pkt_axis_tready = ~m_pkt_axis_tready;
         default: m_pkt_axis_tready = ($urandom_range(3) != 0);
      endcase
      if (srdy_hold)      m_status_ready = 1'b0;
      else if (srdy_rand) m_status_ready = 1'($urandom_range(1));
      else                m_status_ready = 1'b1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (m_pkt_axis_tvalid && m_pkt_axis_tready)
            got_b.push_back({m_pkt_axis_tdata, m_pkt_axis_tkeep,
                             m_pkt_axis_tlast});
         if (m_status_valid && m_status_ready)
            got_s.push_back({m_status_src_ip, m_status_src_port,
                             m_status_len, m_status_err});
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_reset();
      rst = 1'b1;
      s_usr_hdr_valid = 1'b0;
      s_usr_payload_axis_tvalid = 1'b0;
      s_usr_payload_axis_tlast = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      got_b.delete(); exp_b.delete();
      got_s.delete(); exp_s.delete();
      e_pkt = 0; e_drop = 0; e_err = 0;
   endtask

   // Reference model: what the sink should produce for one packet.
   task automatic model_pkt(input logic [111:0] h);
      int bytes;
      logic [2:0] e;
      int len;
      len = int'(h[111:96]);
      bytes = 0;
      if (len < 8) begin
         e_drop++; e_err++;
      end else if (h[95:80] != 16'd1234) begin
         e_drop++;
      end else begin
         foreach (b_data[i]) begin
            exp_b.push_back({b_data[i], b_keep[i],
                             i == b_data.size() - 1});
            bytes += $countones(b_keep[i]);
         end
         e = {1'b0, b_user, bytes != len - 8};
         exp_s.push_back({h[31:0], h[79:64], 16'(bytes), e});
         e_pkt++;
         if (e != 3'b000) e_err++;
      end
   endtask

   task automatic send_pkt(input logic [111:0] h, input bit gaps,
                           input int nmax);
      int t;
      bit last;
      s_usr_hdr_data = h;
      s_usr_hdr_valid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end
      while (!s_usr_hdr_ready && t < 300);
      if (t >= 300) begin
         n_cmp++; n_bad++;
         $display("FAIL hdr handshake timeout: ready %b want 1",
                  s_usr_hdr_ready);
      end
      @(posedge clk); #1 s_usr_hdr_valid = 1'b0;
      for (int i = 0; i < b_data.size() && i < nmax; i++) begin
         if (gaps) begin
            while ($urandom_range(3) == 0) begin
               s_usr_payload_axis_tvalid = 1'b0;
               @(posedge clk); #1;
            end
         end
         last = (i == b_data.size() - 1);
         s_usr_payload_axis_tdata  = b_data[i];
         s_usr_payload_axis_tkeep  = b_keep[i];
         s_usr_payload_axis_tlast  = last;
         s_usr_payload_axis_tuser  = last ? b_user : 1'($urandom_range(1));
         s_usr_payload_axis_tvalid = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end
         while (!s_usr_payload_axis_tready && t < 300);
         if (t >= 300) begin
            n_cmp++; n_bad++;
            $display("FAIL beat handshake timeout: tready %b want 1",
                     s_usr_payload_axis_tready);
         end
         @(posedge clk); #1;
      end
      s_usr_payload_axis_tvalid = 1'b0;
      s_usr_payload_axis_tlast  = 1'b0;
   endtask

   task automatic settle();
      int t;
      t = 0;
      do begin @(negedge clk); t++; end
      while (!s_usr_hdr_ready && t < 500);
      if (t >= 500) begin
         n_cmp++; n_bad++;
         $display("FAIL settle timeout: hdr_ready %b want 1",
                  s_usr_hdr_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic nominal_beats();
      b_data = '{64'h0f0f0f0f0f0f0f0f, 64'h0101010101010101};
      b_keep = '{8'hFF, 8'hFF};
      b_user = 1'b0;
   endtask

   task automatic rand_pkt(output logic [111:0] h);
      int nb, lastn, bytes;
      logic [15:0] len, dp;
      nb = $urandom_range(1, 4);
      lastn = $urandom_range(0, 8);
      b_data.delete(); b_keep.delete();
      for (int i = 0; i < nb; i++) begin
         b_data.push_back({$urandom, $urandom});
         b_keep.push_back(i == nb - 1 ? 8'((1 << lastn) - 1) : 8'hFF);
      end
      bytes = (nb - 1) * 8 + lastn;
      case ($urandom_range(0, 5))
         0:       len = 16'($urandom_range(0, 7));
         1:       len = 16'(bytes + 8 + $urandom_range(1, 5));
         default: len = 16'(bytes + 8);
      endcase
      dp = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 2000))
                                       : 16'd1234;
      b_user = ($urandom_range(0, 4) == 0);
      h = {len, dp, 16'($urandom), $urandom, $urandom};
   endtask

   task automatic test_reset();
      s_usr_hdr_valid = 1'b1;
      s_usr_payload_axis_tvalid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({s_usr_hdr_ready, s_usr_payload_axis_tready, m_pkt_axis_tvalid,
           m_status_valid} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset handshakes: got %b%b%b%b want 0000",
                  s_usr_hdr_ready, s_usr_payload_axis_tready,
                  m_pkt_axis_tvalid, m_status_valid);
      end
      n_cmp++;
      if ({rx_pkt_count, rx_drop_count, rx_err_count} !== 96'd0) begin
         n_bad++;
         $display("FAIL reset counters: got %h %h %h want 0",
                  rx_pkt_count, rx_drop_count, rx_err_count);
      end
      n_cmp++;
      if ({m_status_src_ip, m_status_src_port, m_status_len,
           m_status_err} !== 67'd0) begin
         n_bad++;
         $display("FAIL reset status fields: got %h %h %h %h want 0",
                  m_status_src_ip, m_status_src_port, m_status_len,
                  m_status_err);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      s_usr_hdr_valid = 1'b0;
      s_usr_payload_axis_tvalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({s_usr_hdr_ready, s_usr_payload_axis_tready} !== 2'b10) begin
         n_bad++;
         $display("FAIL post-reset ready: got %b%b want 10",
                  s_usr_hdr_ready, s_usr_payload_axis_tready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_nominal();
      do_reset();
      nominal_beats();
      model_pkt(NOM_HDR);
      send_pkt(NOM_HDR, 1'b0, 2);
      @(negedge clk);
      n_cmp++;
      if (m_status_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL nominal status latency: valid %b want 1",
                  m_status_valid);
      end
      settle();
      n_cmp++;
      if (got_b.size() != exp_b.size()) begin
         n_bad++;
         $display("FAIL nominal beat count: got %0d want %0d",
                  got_b.size(), exp_b.size());
      end else foreach (exp_b[i]) begin
         n_cmp++;
         if (got_b[i] !== exp_b[i]) begin
            n_bad++;
            $display("FAIL nominal beat %0d: got %h want %h",
                     i, got_b[i], exp_b[i]);
         end
      end
      n_cmp++;
      if (got_s.size() != 1) begin
         n_bad++;
         $display("FAIL nominal status count: got %0d want 1", got_s.size());
      end else if (got_s[0] !== {32'h8101A8C0, 16'd1000, 16'd16, 3'b000}) begin
         n_bad++;
         $display("FAIL nominal status: got %h want %h", got_s[0],
                  {32'h8101A8C0, 16'd1000, 16'd16, 3'b000});
      end
      n_cmp++;
      if ({rx_pkt_count, rx_drop_count, rx_err_count} !== {32'd1, 32'd0, 32'd0}) begin
         n_bad++;
         $display("FAIL nominal counters: got %0d %0d %0d want 1 0 0",
                  rx_pkt_count, rx_drop_count, rx_err_count);
      end
   endtask

   task automatic test_port_filter();
      logic [111:0] h;
      do_reset();
      nominal_beats();
      h = NOM_HDR;
      h[95:80] = 16'd80;
      model_pkt(h);
      send_pkt(h, 1'b0, 2);
      settle();
      n_cmp++;
      if (got_b.size() != 0 || got_s.size() != 0) begin
         n_bad++;
         $display("FAIL filter outputs: got %0d beats %0d status want 0 0",
                  got_b.size(), got_s.size());
      end
      n_cmp++;
      if ({rx_pkt_count, rx_drop_count, rx_err_count} !==
          {32'(e_pkt), 32'(e_drop), 32'(e_err)}) begin
         n_bad++;
         $display("FAIL filter counters: got %0d %0d %0d want %0d %0d %0d",
                  rx_pkt_count, rx_drop_count, rx_err_count,
                  e_pkt, e_drop, e_err);
      end
   endtask

   task automatic test_len_mismatch();
      logic [111:0] h;
      do_reset();
      nominal_beats();
      h = NOM_HDR;
      h[111:96] = 16'd20;
      model_pkt(h);
      send_pkt(h, 1'b0, 2);
      settle();
      n_cmp++;
      if (got_s.size() != 1) begin
         n_bad++;
         $display("FAIL mismatch status count: got %0d want 1", got_s.size());
      end else if (got_s[0][18:0] !== {16'd16, 3'b001}) begin
         n_bad++;
         $display("FAIL mismatch len/err: got %h want %h",
                  got_s[0][18:0], {16'd16, 3'b001});
      end
      n_cmp++;
      if ({rx_pkt_count, rx_drop_count, rx_err_count} !== {32'd1, 32'd0, 32'd1}) begin
         n_bad++;
         $display("FAIL mismatch counters: got %0d %0d %0d want 1 0 1",
                  rx_pkt_count, rx_drop_count, rx_err_count);
      end
   endtask

   task automatic test_short_and_tuser();
      logic [111:0] h;
      do_reset();
      b_data = '{64'h1122334455667788};
      b_keep = '{8'h0F};
      b_user = 1'b0;
      h = NOM_HDR;
      h[111:96] = 16'd4;
      model_pkt(h);
      send_pkt(h, 1'b0, 1);
      nominal_beats();
      b_user = 1'b1;
      model_pkt(NOM_HDR);
      send_pkt(NOM_HDR, 1'b0, 2);
      b_data = '{64'hDEADBEEF00000000};
      b_keep = '{8'h00};
      b_user = 1'b0;
      h = NOM_HDR;
      h[111:96] = 16'd8;
      model_pkt(h);
      send_pkt(h, 1'b0, 1);
      settle();
      n_cmp++;
      if (got_s.size() != 2) begin
         n_bad++;
         $display("FAIL short/tuser status count: got %0d want 2",
                  got_s.size());
      end else begin
         n_cmp++;
         if (got_s[0][2:0] !== 3'b010) begin
            n_bad++;
            $display("FAIL tuser err: got %b want 010", got_s[0][2:0]);
         end
         n_cmp++;
         if (got_s[1] !== exp_s[1]) begin
            n_bad++;
            $display("FAIL zero-length status: got %h want %h",
                     got_s[1], exp_s[1]);
         end
      end
      n_cmp++;
      if ({rx_pkt_count, rx_drop_count, rx_err_count} !== {32'd2, 32'd1, 32'd2}) begin
         n_bad++;
         $display("FAIL short/tuser counters: got %0d %0d %0d want 2 1 2",
                  rx_pkt_count, rx_drop_count, rx_err_count);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      prdy_mode = 1;
      for (int p = 0; p < 4; p++) begin
         b_data.delete(); b_keep.delete();
         for (int i = 0; i < 3; i++) begin
            b_data.push_back({$urandom, $urandom});
            b_keep.push_back(8'hFF);
         end
         b_user = 1'b0;
         model_pkt({16'd32, NOM_HDR[95:0]});
         send_pkt({16'd32, NOM_HDR[95:0]}, 1'b0, 3);
      end
      settle();
      prdy_mode = 0;
      n_cmp++;
      if (got_b.size() != exp_b.size()) begin
         n_bad++;
         $display("FAIL backpressure beat count: got %0d want %0d",
                  got_b.size(), exp_b.size());
      end else foreach (exp_b[i]) begin
         n_cmp++;
         if (got_b[i] !== exp_b[i]) begin
            n_bad++;
            $display("FAIL backpressure beat %0d: got %h want %h",
                     i, got_b[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_status_stall();
      sts_t want;
      do_reset();
      srdy_hold = 1'b1;
      nominal_beats();
      b_data[1] = {$urandom, $urandom};
      model_pkt(NOM_HDR);
      want = exp_s[0];
      send_pkt(NOM_HDR, 1'b0, 2);
      repeat (5) begin
         @(negedge clk);
         n_cmp++;
         if ({m_status_valid, s_usr_hdr_ready, m_status_src_ip,
              m_status_src_port, m_status_len, m_status_err} !==
             {1'b1, 1'b0, want}) begin
            n_bad++;
            $display("FAIL stall hold: got %b %b %h want 1 0 %h",
                     m_status_valid, s_usr_hdr_ready,
                     {m_status_src_ip, m_status_src_port, m_status_len,
                      m_status_err}, want);
         end
      end
      @(posedge clk);
      #1 srdy_hold = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({s_usr_hdr_ready, rx_pkt_count} !== {1'b1, 32'd1}) begin
         n_bad++;
         $display("FAIL stall release: got ready %b pkts %0d want 1 1",
                  s_usr_hdr_ready, rx_pkt_count);
      end
      settle();
      n_cmp++;
      if (got_s.size() != 1 || got_s[0] !== want) begin
         n_bad++;
         $display("FAIL stall status: got %0d records want 1 of %h",
                  got_s.size(), want);
      end
   endtask

   task automatic test_back_to_back();
      logic [111:0] h;
      do_reset();
      prdy_mode = 2;
      srdy_rand = 1'b1;
      for (int p = 0; p < 40; p++) begin
         rand_pkt(h);
         model_pkt(h);
         send_pkt(h, 1'b1, 99);
      end
      settle();
      prdy_mode = 0;
      srdy_rand = 1'b0;
      n_cmp++;
      if (got_b.size() != exp_b.size()) begin
         n_bad++;
         $display("FAIL random beat count: got %0d want %0d",
                  got_b.size(), exp_b.size());
      end else foreach (exp_b[i]) begin
         n_cmp++;
         if (got_b[i] !== exp_b[i]) begin
            n_bad++;
            $display("FAIL random beat %0d: got %h want %h",
                     i, got_b[i], exp_b[i]);
         end
      end
      n_cmp++;
      if (got_s.size() != exp_s.size()) begin
         n_bad++;
         $display("FAIL random status count: got %0d want %0d",
                  got_s.size(), exp_s.size());
      end else foreach (exp_s[i]) begin
         n_cmp++;
         if (got_s[i] !== exp_s[i]) begin
            n_bad++;
            $display("FAIL random status %0d: got %h want %h",
                     i, got_s[i], exp_s[i]);
         end
      end
      n_cmp++;
      if ({rx_pkt_count, rx_drop_count, rx_err_count} !==
          {32'(e_pkt), 32'(e_drop), 32'(e_err)}) begin
         n_bad++;
         $display("FAIL random counters: got %0d %0d %0d want %0d %0d %0d",
                  rx_pkt_count, rx_drop_count, rx_err_count,
                  e_pkt, e_drop, e_err);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      nominal_beats();
      for (int p = 0; p < 10; p++) begin
         model_pkt(NOM_HDR);
         send_pkt(NOM_HDR, 1'b0, 2);
      end
      settle();
      n_cmp++;
      if (rx_pkt_count !== 32'd10 || got_s.size() != 10) begin
         n_bad++;
         $display("FAIL 10 packets: got %0d count %0d records want 10 10",
                  rx_pkt_count, got_s.size());
      end
      send_pkt(NOM_HDR, 1'b0, 1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({rx_pkt_count, rx_drop_count, rx_err_count} !== 96'd0) begin
         n_bad++;
         $display("FAIL mid reset counters: got %0d %0d %0d want 0 0 0",
                  rx_pkt_count, rx_drop_count, rx_err_count);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      s_usr_payload_axis_tdata  = b_data[1];
      s_usr_payload_axis_tkeep  = b_keep[1];
      s_usr_payload_axis_tlast  = 1'b1;
      s_usr_payload_axis_tvalid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if ({s_usr_payload_axis_tready, s_usr_hdr_ready,
              m_status_valid} !== 3'b010) begin
            n_bad++;
            $display("FAIL stale beat after reset: got %b%b%b want 010",
                     s_usr_payload_axis_tready, s_usr_hdr_ready,
                     m_status_valid);
         end
      end
      @(posedge clk);
      #1 s_usr_payload_axis_tvalid = 1'b0;
      s_usr_payload_axis_tlast = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (got_s.size() != 10 || rx_pkt_count !== 32'd0) begin
         n_bad++;
         $display("FAIL abandoned packet: got %0d records pkts %0d want 10 0",
                  got_s.size(), rx_pkt_count);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_port_filter();
      test_len_mismatch();
      test_short_and_tuser();
      test_backpressure();
      test_status_stall();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
